// File: rtl/audio_mem_playback_reader.sv
// Read master streaming a (base, length) window of 32-bit stereo words into a FIFO; RD_LATENCY+1 cycles issue-to-capture.
// Reads issue only while FIFO slots remain unreserved, so sample_ready backpressure simply stalls issue.
module audio_mem_playback_reader #(
    parameter int ADDR_W     = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic              mem_clken,
    input  logic [31:0]       mem_readdata,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic [15:0]       sample_left,
    output logic [15:0]       sample_right,
    output logic              busy,
    output logic              done
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = CW + 1;
    localparam logic [OW-1:0] DEPTH_V = OW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [ADDR_W:0]     idx_q, idx_d;
    logic                loop_q, loop_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                cs_q, cs_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                flush_q, flush_d;
    logic [RD_LATENCY-1:0] pipe_q, pipe_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [31:0]         fifo_mem_q [FIFO_DEPTH];

    // pend[0] is the read on the bus now, pend[RD_LATENCY] is the one returning this cycle
    logic [RD_LATENCY:0] pend;
    logic [OW-1:0]       pend_cnt;
    logic [OW-1:0]       occ;
    logic                stop_act, push, pop;

    assign pend     = {pipe_q, cs_q};
    assign stop_act = stop && (state_q != IDLE);
    assign push     = pend[RD_LATENCY] && !flush_q && !stop_act;
    assign pop      = sample_valid && sample_ready;
    assign occ      = OW'(count_q) + pend_cnt;

    always_comb begin
        pend_cnt = '0;
        for (int i = 0; i <= RD_LATENCY; i++) begin
            pend_cnt = pend_cnt + OW'(pend[i]);
        end
    end

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        len_d    = len_q;
        idx_d    = idx_q;
        loop_d   = loop_q;
        addr_d   = addr_q;
        cs_d     = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        flush_d  = flush_q;
        pipe_d   = pend[RD_LATENCY-1:0];
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);

        if (stop_act) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    base_d = base_addr;
                    len_d  = length;
                    loop_d = loop;
                    if (length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        busy_d  = 1'b1;
                        idx_d   = '0;
                        flush_d = 1'b0;
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                if (stop_act) begin
                    flush_d = 1'b1;
                    if (|pend[RD_LATENCY-1:0]) begin
                        state_d = DRAIN;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end else if (occ < DEPTH_V) begin
                    cs_d   = 1'b1;
                    addr_d = base_q + idx_q[ADDR_W-1:0];
                    if (idx_q == len_q - (ADDR_W+1)'(1)) begin
                        if (loop_q) idx_d = '0;
                        else        state_d = DRAIN;
                    end else begin
                        idx_d = idx_q + (ADDR_W+1)'(1);
                    end
                end
            end
            DRAIN: begin
                if (stop_act || flush_q) begin
                    flush_d = 1'b1;
                    if (!(|pend[RD_LATENCY-1:0])) begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end else if (count_q == '0 && pend == '0) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            base_q   <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            loop_q   <= 1'b0;
            addr_q   <= '0;
            cs_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            flush_q  <= 1'b0;
            pipe_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            loop_q   <= loop_d;
            addr_q   <= addr_d;
            cs_q     <= cs_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            flush_q  <= flush_d;
            pipe_q   <= pipe_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= mem_readdata;
    end

    assign mem_address    = addr_q;
    assign mem_chipselect = cs_q;
    assign mem_write      = 1'b0;
    assign mem_byteenable = 4'hF;
    assign mem_clken      = 1'b1;
    assign sample_valid   = (count_q != '0);
    assign sample_left    = fifo_mem_q[rd_ptr_q][31:16];
    assign sample_right   = fifo_mem_q[rd_ptr_q][15:0];
    assign busy           = busy_q;
    assign done           = done_q;
endmodule

// File: tb/tb_audio_mem_playback_reader.sv
// Bench for audio_mem_playback_reader: synchronous RAM model holding {addr, ~addr}, address and sample scoreboards.
module tb_audio_mem_playback_reader;
    localparam int ADDR_W     = 16;
    localparam int FIFO_DEPTH = 8;
    localparam int RD_LATENCY = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop = 1'b0;
    logic [15:0] base_addr = '0;
    logic [16:0] length = '0;
    logic [15:0] mem_address;
    logic        mem_chipselect;
    logic        mem_write;
    logic [3:0]  mem_byteenable;
    logic        mem_clken;
    logic [31:0] mem_readdata = '0;
    logic        sample_valid;
    logic        sample_ready = 1'b0;
    logic [15:0] sample_left;
    logic [15:0] sample_right;
    logic        busy;
    logic        done;

    audio_mem_playback_reader #(
        .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH), .RD_LATENCY(RD_LATENCY)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .loop(loop),
        .base_addr(base_addr), .length(length),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_byteenable(mem_byteenable), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .sample_left(sample_left), .sample_right(sample_right),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [15:0] a);
        return {a, ~a};
    endfunction

    always @(posedge clk) begin
        if (mem_chipselect) mem_readdata <= word_of(mem_address);
    end

    int checks = 0, passes = 0;
    int done_cnt = 0, rd_cnt = 0, pop_cnt = 0, cyc = 0, done_cyc = 0, last_pop_cyc = 0;
    logic [31:0] exp_smp[$];
    logic [15:0] exp_addr[$];
    bit          prev_hold = 1'b0;
    logic [31:0] prev_dat = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %h required %h", name, act, req);
    endtask

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            prev_hold = 1'b0;
        end else begin
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (mem_chipselect) begin
                rd_cnt++;
                if (exp_addr.size() == 0) begin
                    checks++;
                    $display("FAIL extra_read: got address %h required no read", mem_address);
                end else begin
                    check("read_addr", {16'h0, mem_address}, {16'h0, exp_addr.pop_front()});
                end
            end
            if (prev_hold && sample_valid)
                check("hold_stable", {sample_left, sample_right}, prev_dat);
            prev_hold = sample_valid && !sample_ready;
            prev_dat  = {sample_left, sample_right};
            if (sample_valid && sample_ready) begin
                pop_cnt++;
                last_pop_cyc = cyc;
                if (exp_smp.size() == 0) begin
                    checks++;
                    $display("FAIL extra_sample: got %h required no sample", {sample_left, sample_right});
                end else begin
                    check("sample", {sample_left, sample_right}, exp_smp.pop_front());
                end
            end
        end
    end

    // All tasks start and end #1 after a rising edge.
    task automatic start_win(input logic [15:0] b, input logic [16:0] l, input bit lp, input int reps);
        logic [15:0] a;
        start = 1'b1;
        base_addr = b;
        length = l;
        loop = lp;
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < int'(l); i++) begin
                a = b + 16'(i);
                exp_addr.push_back(a);
                exp_smp.push_back(word_of(a));
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (busy && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, {31'h0, busy}, 32'h0);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic do_stop(output int n);
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        exp_smp.delete();
        exp_addr.delete();
        n = 1;
        while (busy && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n, d0, r0, p0, stop_at;
        bit stopped;
        logic [15:0] b;
        logic [16:0] l;

        repeat (3) @(posedge clk);
        #1;
        check("rst_address", {16'h0, mem_address}, 32'h0);
        check("rst_chipselect", {31'h0, mem_chipselect}, 32'h0);
        check("rst_valid", {31'h0, sample_valid}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("const_write", {31'h0, mem_write}, 32'h0);
        check("const_byteenable", {28'h0, mem_byteenable}, 32'hF);
        check("const_clken", {31'h0, mem_clken}, 32'h1);
        reset = 1'b0;
        @(posedge clk); #1;

        // Basic window, ready held high
        sample_ready = 1'b1;
        d0 = done_cnt;
        start_win(16'h0010, 17'd4, 1'b0, 1);
        wait_idle(100, "t1_idle");
        check("t1_done_count", 32'(done_cnt - d0), 32'd1);
        check("t1_samples_left", 32'(exp_smp.size()), 32'd0);
        check("t1_done_after_last_pop", 32'(done_cyc > last_pop_cyc), 32'd1);

        // Backpressure on a finite window
        sample_ready = 1'b0;
        d0 = done_cnt;
        r0 = rd_cnt;
        start_win(16'h0010, 17'd4, 1'b0, 1);
        repeat (20) begin @(posedge clk); #1; end
        check("t2_reads_issued", 32'(rd_cnt - r0), 32'd4);
        check("t2_valid_held", {31'h0, sample_valid}, 32'h1);
        sample_ready = 1'b1;
        wait_idle(100, "t2_idle");
        check("t2_done_count", 32'(done_cnt - d0), 32'd1);
        check("t2_samples_left", 32'(exp_smp.size()), 32'd0);

        // Looping window stalled: issue must stop at FIFO_DEPTH, then stop and replay
        sample_ready = 1'b0;
        d0 = done_cnt;
        r0 = rd_cnt;
        start_win(16'h0100, 17'd4, 1'b1, 6);
        repeat (30) begin @(posedge clk); #1; end
        check("t3_reads_reserved", 32'(rd_cnt - r0), 32'(FIFO_DEPTH));
        do_stop(n);
        check("t3_stop_busy_cycles", 32'(n <= RD_LATENCY + 1), 32'd1);
        check("t3_stop_busy", {31'h0, busy}, 32'h0);
        sample_ready = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        check("t3_flushed_valid", {31'h0, sample_valid}, 32'h0);
        check("t3_no_done", 32'(done_cnt - d0), 32'd0);
        start_win(16'h0100, 17'd4, 1'b0, 1);
        wait_idle(100, "t3_replay_idle");
        check("t3_replay_done", 32'(done_cnt - d0), 32'd1);
        check("t3_replay_left", 32'(exp_smp.size()), 32'd0);

        // Address wrap with looping
        sample_ready = 1'b1;
        d0 = done_cnt;
        p0 = pop_cnt;
        start_win(16'hFFFE, 17'd4, 1'b1, 10);
        n = 0;
        while (pop_cnt - p0 < 12 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("t4_pops", 32'(pop_cnt - p0 >= 12), 32'd1);
        do_stop(n);
        check("t4_stop_busy_cycles", 32'(n <= RD_LATENCY + 1), 32'd1);
        repeat (4) begin @(posedge clk); #1; end
        check("t4_no_done", 32'(done_cnt - d0), 32'd0);

        // Zero-length window
        d0 = done_cnt;
        r0 = rd_cnt;
        start_win(16'h1234, 17'd0, 1'b0, 1);
        check("t5_done_pulse", {31'h0, done}, 32'h1);
        check("t5_busy", {31'h0, busy}, 32'h0);
        @(posedge clk); #1;
        check("t5_done_clear", {31'h0, done}, 32'h0);
        repeat (3) begin @(posedge clk); #1; end
        check("t5_no_reads", 32'(rd_cnt - r0), 32'd0);
        check("t5_done_count", 32'(done_cnt - d0), 32'd1);

        // Reset with a full FIFO mid-fetch
        sample_ready = 1'b0;
        start_win(16'h0200, 17'd20, 1'b0, 1);
        repeat (20) begin @(posedge clk); #1; end
        check("t6_valid_before", {31'h0, sample_valid}, 32'h1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("t6_address", {16'h0, mem_address}, 32'h0);
        check("t6_chipselect", {31'h0, mem_chipselect}, 32'h0);
        check("t6_valid", {31'h0, sample_valid}, 32'h0);
        check("t6_busy", {31'h0, busy}, 32'h0);
        check("t6_done", {31'h0, done}, 32'h0);
        exp_smp.delete();
        exp_addr.delete();
        reset = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("t6_idle_after", {31'h0, busy}, 32'h0);

        // Randomized windows, random ready, ignored re-starts and occasional stops
        for (int it = 0; it < 16; it++) begin
            b = 16'($urandom);
            l = 17'($urandom_range(1, 24));
            d0 = done_cnt;
            stop_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 20)) : -1;
            stopped = 1'b0;
            sample_ready = ($urandom_range(0, 3) != 0);
            start_win(b, l, 1'b0, 1);
            n = 0;
            while (busy && n < 600) begin
                if (n == stop_at) stop = 1'b1;
                if (n == 3) begin
                    start = 1'b1;
                    base_addr = 16'($urandom);
                    length = 17'd5;
                end
                sample_ready = ($urandom_range(0, 3) != 0);
                @(posedge clk); #1;
                start = 1'b0;
                if (stop) begin
                    stop = 1'b0;
                    stopped = 1'b1;
                    exp_smp.delete();
                    exp_addr.delete();
                end
                n++;
            end
            sample_ready = 1'b1;
            repeat (3) begin @(posedge clk); #1; end
            check("rand_idle", {31'h0, busy}, 32'h0);
            if (stopped) begin
                check("rand_stop_no_done", 32'(done_cnt - d0), 32'd0);
            end else begin
                check("rand_done", 32'(done_cnt - d0), 32'd1);
                check("rand_samples_left", 32'(exp_smp.size()), 32'd0);
            end
            exp_smp.delete();
            exp_addr.delete();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
